// File: rtl/alu_bist_pkg.sv
// alu_bist_pkg
// Shared definitions for the replica reintegration controller:
//   - state_t     : controller FSM states
//   - NUM_VEC     : number of built-in self-test vectors per pass
//   - VEC_*       : vector operands, ALU control and golden result/zero flag
package alu_bist_pkg;

    localparam int NUM_VEC = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_APPLY  = 3'd2,
        S_CHECK  = 3'd3,
        S_PASS   = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    // Vectors exercise add, subtract, and, or and set-less-than, including
    // carry-out wrap to zero and the zero flag in both polarities.
    localparam logic [31:0] VEC_A [NUM_VEC] = '{
        32'h0000_0005, 32'h0000_0005, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
        32'h0000_0001, 32'h0000_0002, 32'h1234_5678, 32'hFFFF_FFFF
    };

    localparam logic [31:0] VEC_B [NUM_VEC] = '{
        32'h0000_0003, 32'h0000_0003, 32'h0FF0_0FF0, 32'h0F0F_0F0F,
        32'h0000_0002, 32'h0000_0001, 32'h1234_5678, 32'h0000_0001
    };

    localparam logic [2:0] VEC_ALUCONT [NUM_VEC] = '{
        3'b010, 3'b110, 3'b000, 3'b001,
        3'b111, 3'b111, 3'b110, 3'b010
    };

    localparam logic [31:0] VEC_RESULT [NUM_VEC] = '{
        32'h0000_0008, 32'h0000_0002, 32'h00F0_00F0, 32'hFFFF_FFFF,
        32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000
    };

    localparam logic VEC_ZERO [NUM_VEC] = '{
        1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b1, 1'b1, 1'b1
    };

endpackage

// File: rtl/bist_vector_rom.sv
// bist_vector_rom
// Combinational lookup of one self-test vector and its golden response.
// Ports:
//   k          : vector index (0 .. NUM_VEC-1)
//   vec_a      : operand a
//   vec_b      : operand b
//   vec_alucont: ALU control code
//   exp_result : golden ALU result
//   exp_zero   : golden zero flag
module bist_vector_rom
    import alu_bist_pkg::*;
(
    input  logic [2:0]  k,
    output logic [31:0] vec_a,
    output logic [31:0] vec_b,
    output logic [2:0]  vec_alucont,
    output logic [31:0] exp_result,
    output logic        exp_zero
);

    assign vec_a       = VEC_A[k];
    assign vec_b       = VEC_B[k];
    assign vec_alucont = VEC_ALUCONT[k];
    assign exp_result  = VEC_RESULT[k];
    assign exp_zero    = VEC_ZERO[k];

endmodule

// File: rtl/alu_replica_reintegrator.sv
// alu_replica_reintegrator
// Background self-test of quarantined ALU replicas. A quarantined, non-retired
// replica is picked round-robin, driven through the fixed vector set and its
// result/zero outputs are compared with golden values. Enough consecutive
// clean passes pulse a re-enable request; repeated failures retire the
// replica until reset.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   fault_mask      : replicas currently quarantined by the voter
//   bist_en         : testing allowed
//   rep_result/zero : outputs of the replica selected by bist_sel
//   bist_sel        : one-hot replica under test (zero when not driving)
//   bist_a/b/alucont: test stimulus to the selected replica
//   reenable        : one-cycle re-enable request for reenable_idx
//   retired         : sticky per-replica retirement flags
//   busy            : controller is not idle
module alu_replica_reintegrator
    import alu_bist_pkg::*;
#(
    parameter int NREP      = 9,
    parameter int PASSES    = 4,
    parameter int MAX_FAILS = 3,
    parameter int IDLE_GAP  = 16
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NREP-1:0] fault_mask,
    input  logic            bist_en,
    input  logic [31:0]     rep_result,
    input  logic            rep_zero,
    output logic [NREP-1:0] bist_sel,
    output logic [31:0]     bist_a,
    output logic [31:0]     bist_b,
    output logic [2:0]      bist_alucont,
    output logic            reenable,
    output logic [3:0]      reenable_idx,
    output logic [NREP-1:0] retired,
    output logic            busy
);

    localparam int GAP_W = (IDLE_GAP < 2) ? 1 : $clog2(IDLE_GAP + 1);

    state_t            state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [3:0]        target_q, target_d;
    logic [3:0]        rr_ptr_q, rr_ptr_d;
    logic [2:0]        k_q, k_d;
    logic [2:0]        pass_cnt_q [NREP];
    logic [2:0]        pass_cnt_d [NREP];
    logic [1:0]        fail_cnt_q [NREP];
    logic [1:0]        fail_cnt_d [NREP];
    logic [NREP-1:0]   retired_q, retired_d;
    logic [NREP-1:0]   bist_sel_q, bist_sel_d;
    logic [31:0]       bist_a_q, bist_a_d;
    logic [31:0]       bist_b_q, bist_b_d;
    logic [2:0]        bist_alucont_q, bist_alucont_d;
    logic              reenable_q, reenable_d;
    logic [3:0]        reenable_idx_q, reenable_idx_d;
    logic              busy_q, busy_d;

    logic [31:0]       vec_a, vec_b, exp_result;
    logic [2:0]        vec_alucont;
    logic              exp_zero;

    logic [NREP-1:0]   cand;
    logic              rr_found;
    logic [3:0]        rr_pick;
    int                rr_idx;
    logic [2:0]        pass_inc;
    logic [1:0]        fail_inc;
    logic              target_masked;

    bist_vector_rom u_rom (
        .k           (k_q),
        .vec_a       (vec_a),
        .vec_b       (vec_b),
        .vec_alucont (vec_alucont),
        .exp_result  (exp_result),
        .exp_zero    (exp_zero)
    );

    assign cand          = fault_mask & ~retired_q;
    assign target_masked = fault_mask[target_q];

    // Round-robin search: first candidate strictly after the last tested
    // replica, wrapping, so the last tested one is considered last.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_idx   = 0;
        for (int i = 1; i <= NREP; i++) begin
            rr_idx = int'(rr_ptr_q) + i;
            if (rr_idx >= NREP) begin
                rr_idx = rr_idx - NREP;
            end
            if (!rr_found && cand[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = 4'(rr_idx);
            end
        end
    end

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d        = state_q;
        gap_d          = gap_q;
        target_d       = target_q;
        rr_ptr_d       = rr_ptr_q;
        k_d            = k_q;
        pass_cnt_d     = pass_cnt_q;
        fail_cnt_d     = fail_cnt_q;
        retired_d      = retired_q;
        bist_sel_d     = '0;
        bist_a_d       = '0;
        bist_b_d       = '0;
        bist_alucont_d = '0;
        reenable_d     = 1'b0;
        reenable_idx_d = '0;
        pass_inc       = (pass_cnt_q[target_q] == 3'd7) ? 3'd7 : pass_cnt_q[target_q] + 3'd1;
        fail_inc       = (fail_cnt_q[target_q] == 2'd3) ? 2'd3 : fail_cnt_q[target_q] + 2'd1;

        case (state_q)
            S_IDLE: begin
                if (gap_q != GAP_W'(IDLE_GAP)) begin
                    gap_d = gap_q + 1'b1;
                end else if (bist_en && (|cand)) begin
                    gap_d   = '0;
                    state_d = S_SELECT;
                end
            end

            S_SELECT: begin
                // The candidate set may have emptied since IDLE decided to go.
                if (rr_found) begin
                    target_d = rr_pick;
                    rr_ptr_d = rr_pick;
                    k_d      = '0;
                    state_d  = S_APPLY;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_APPLY: begin
                // Stimulus is registered here so it is stable for all of CHECK.
                if (!target_masked) begin
                    state_d = S_IDLE;
                end else begin
                    bist_sel_d     = {{(NREP-1){1'b0}}, 1'b1} << target_q;
                    bist_a_d       = vec_a;
                    bist_b_d       = vec_b;
                    bist_alucont_d = vec_alucont;
                    state_d        = S_CHECK;
                end
            end

            S_CHECK: begin
                // External re-enable and test disable both end the attempt
                // without touching the replica's counters.
                if (!target_masked || !bist_en) begin
                    state_d = S_IDLE;
                end else if ({rep_result, rep_zero} != {exp_result, exp_zero}) begin
                    state_d = S_FAIL;
                end else if (k_q == 3'(NUM_VEC - 1)) begin
                    state_d = S_PASS;
                end else begin
                    k_d     = k_q + 3'd1;
                    state_d = S_APPLY;
                end
            end

            S_PASS: begin
                if (pass_inc == 3'(PASSES)) begin
                    reenable_d           = 1'b1;
                    reenable_idx_d       = target_q;
                    pass_cnt_d[target_q] = '0;
                    fail_cnt_d[target_q] = '0;
                end else begin
                    pass_cnt_d[target_q] = pass_inc;
                end
                state_d = S_IDLE;
            end

            S_FAIL: begin
                pass_cnt_d[target_q] = '0;
                fail_cnt_d[target_q] = fail_inc;
                if (fail_inc == 2'(MAX_FAILS)) begin
                    retired_d[target_q] = 1'b1;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // All state and outputs; reset starts the round-robin search at replica 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            gap_q          <= '0;
            target_q       <= '0;
            rr_ptr_q       <= 4'(NREP - 1);
            k_q            <= '0;
            pass_cnt_q     <= '{default: '0};
            fail_cnt_q     <= '{default: '0};
            retired_q      <= '0;
            bist_sel_q     <= '0;
            bist_a_q       <= '0;
            bist_b_q       <= '0;
            bist_alucont_q <= '0;
            reenable_q     <= 1'b0;
            reenable_idx_q <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            gap_q          <= gap_d;
            target_q       <= target_d;
            rr_ptr_q       <= rr_ptr_d;
            k_q            <= k_d;
            pass_cnt_q     <= pass_cnt_d;
            fail_cnt_q     <= fail_cnt_d;
            retired_q      <= retired_d;
            bist_sel_q     <= bist_sel_d;
            bist_a_q       <= bist_a_d;
            bist_b_q       <= bist_b_d;
            bist_alucont_q <= bist_alucont_d;
            reenable_q     <= reenable_d;
            reenable_idx_q <= reenable_idx_d;
            busy_q         <= busy_d;
        end
    end

    assign bist_sel     = bist_sel_q;
    assign bist_a       = bist_a_q;
    assign bist_b       = bist_b_q;
    assign bist_alucont = bist_alucont_q;
    assign reenable     = reenable_q;
    assign reenable_idx = reenable_idx_q;
    assign retired      = retired_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_alu_replica_reintegrator.sv
// tb_alu_replica_reintegrator
// Scoreboard bench: scenarios push the replica indices they expect to be
// tested and the re-enable indices they expect to see; a monitor pops and
// compares whenever an attempt starts or reenable pulses.
module tb_alu_replica_reintegrator;

    localparam int NREP = 9;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREP-1:0] fault_mask;
    logic            bist_en;
    logic [31:0]     rep_result;
    logic            rep_zero;
    logic [NREP-1:0] bist_sel;
    logic [31:0]     bist_a;
    logic [31:0]     bist_b;
    logic [2:0]      bist_alucont;
    logic            reenable;
    logic [3:0]      reenable_idx;
    logic [NREP-1:0] retired;
    logic            busy;

    int   tests = 0;
    int   errors = 0;
    int   cyc = 0;
    int   reen_count = 0;
    int   reen_cycle = 0;
    int   reen_attempt = 0;
    int   attempt_count = 0;
    bit   attempt_seen = 1'b0;
    bit   stuck5 = 1'b0;
    bit   found;
    bit   any_busy;
    int   sel_q[$];
    int   re_q[$];
    logic [31:0] rep_raw;

    alu_replica_reintegrator #(
        .NREP      (NREP),
        .PASSES    (4),
        .MAX_FAILS (3),
        .IDLE_GAP  (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fault_mask   (fault_mask),
        .bist_en      (bist_en),
        .rep_result   (rep_result),
        .rep_zero     (rep_zero),
        .bist_sel     (bist_sel),
        .bist_a       (bist_a),
        .bist_b       (bist_b),
        .bist_alucont (bist_alucont),
        .reenable     (reenable),
        .reenable_idx (reenable_idx),
        .retired      (retired),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Behavioural replica ALU; replica 5 can have result bit 0 stuck at 1.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] c);
        case (c)
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        rep_raw = alu_model(bist_a, bist_b, bist_alucont);
        if (stuck5 && bist_sel[5]) rep_raw[0] = 1'b1;
    end

    assign rep_result = rep_raw;
    assign rep_zero   = (rep_raw == 32'd0);

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [NREP-1:0] mask, input logic en);
        fault_mask = mask;
        bist_en    = en;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        sel_q.delete();
        re_q.delete();
        stuck5        = 1'b0;
        reen_count    = 0;
        reen_attempt  = 0;
        attempt_count = 0;
        apply_stimulus('0, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_queues(input string name, input int budget);
        int n;
        n = 0;
        while ((sel_q.size() != 0 || re_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output(name, 32'(sel_q.size() + re_q.size()), 32'd0);
    endtask

    task automatic expect_idle(input string name, input int cycles);
        any_busy = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (busy) any_busy = 1'b1;
        end
        check_output(name, 32'(any_busy), 32'd0);
    endtask

    // Monitor: compares tested replica at the first driven CHECK of each
    // attempt and every reenable pulse against the scoreboard queues.
    always @(negedge clk) begin
        int exp_idx;
        logic [NREP-1:0] exp_sel;
        if (reset) begin
            attempt_seen = 1'b0;
        end else begin
            if (!busy) begin
                attempt_seen = 1'b0;
            end else if (bist_sel != '0 && !attempt_seen) begin
                attempt_seen = 1'b1;
                attempt_count++;
                check_output("sel_not_retired", 32'(bist_sel & retired), 32'd0);
                if (sel_q.size() > 0) begin
                    exp_idx = sel_q.pop_front();
                    exp_sel = NREP'(1) << exp_idx;
                    check_output("sel_target", 32'(bist_sel), 32'(exp_sel));
                end
            end
            if (reenable) begin
                reen_count++;
                reen_cycle   = cyc;
                reen_attempt = attempt_count;
                if (re_q.size() == 0) begin
                    check_output("unexpected_reenable", 32'(reenable), 32'd0);
                end else begin
                    exp_idx = re_q.pop_front();
                    check_output("reenable_idx", 32'(reenable_idx), 32'(exp_idx));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0;
        apply_stimulus('0, 1'b0);
        #2;

        // Reset values, sampled while reset is held.
        reset = 1'b1;
        @(negedge clk);
        check_output("rst_bist_sel", 32'(bist_sel), 32'd0);
        check_output("rst_bist_a", bist_a, 32'd0);
        check_output("rst_reenable", 32'(reenable), 32'd0);
        check_output("rst_retired", 32'(retired), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);

        // Single healthy replica 2: four clean passes then one re-enable,
        // 17 idle + 18 test cycles per attempt -> pulse near cycle 140.
        $display("[TB] scenario: healthy replica 2");
        apply_reset();
        apply_stimulus(9'b000000100, 1'b1);
        repeat (4) sel_q.push_back(2);
        re_q.push_back(2);
        wait_queues("s1_queues", 400);
        apply_stimulus('0, 1'b1);
        check_output("s1_reen_count", 32'(reen_count), 32'd1);
        check_output("s1_reen_attempt", 32'(reen_attempt), 32'd4);
        check_output("s1_reen_window", 32'(reen_cycle >= 130 && reen_cycle <= 150), 32'd1);
        expect_idle("s1_idle_after_reenable", 60);

        // Round-robin between replicas 1 and 7.
        $display("[TB] scenario: round-robin 1/7");
        apply_reset();
        apply_stimulus(9'b010000010, 1'b1);
        sel_q.push_back(1); sel_q.push_back(7); sel_q.push_back(1); sel_q.push_back(7);
        wait_queues("s3_rr_order", 400);
        check_output("s3_no_reenable", 32'(reen_count), 32'd0);

        // Abort during CHECK of v3 when replica 4 is re-enabled externally;
        // the aborted attempt must not count toward the four passes.
        $display("[TB] scenario: abort on replica 4");
        apply_reset();
        apply_stimulus(9'b000010000, 1'b1);
        sel_q.push_back(4);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (busy && bist_sel[4] && bist_a == 32'hF0F0F0F0 && bist_alucont == 3'b001)
                found = 1'b1;
        end
        check_output("s4_reach_v3", 32'(found), 32'd1);
        apply_stimulus('0, 1'b1);
        @(negedge clk);
        check_output("s4_abort_idle", 32'(busy), 32'd0);
        check_output("s4_no_reenable", 32'(reen_count), 32'd0);
        repeat (5) @(negedge clk);
        apply_stimulus(9'b000010000, 1'b1);
        repeat (4) sel_q.push_back(4);
        re_q.push_back(4);
        wait_queues("s4_four_more_passes", 600);
        check_output("s4_reen_attempt", 32'(reen_attempt), 32'd5);

        // bist_en dropped during CHECK of v2 on replica 6.
        $display("[TB] scenario: bist_en drop on replica 6");
        apply_reset();
        apply_stimulus(9'b001000000, 1'b1);
        sel_q.push_back(6);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (busy && bist_sel[6] && bist_a == 32'hF0F0F0F0 && bist_alucont == 3'b000)
                found = 1'b1;
        end
        check_output("s5_reach_v2", 32'(found), 32'd1);
        bist_en = 1'b0;
        @(negedge clk);
        check_output("s5_busy_falls", 32'(busy), 32'd0);
        expect_idle("s5_held_idle", 30);
        bist_en = 1'b1;
        repeat (4) sel_q.push_back(6);
        re_q.push_back(6);
        wait_queues("s5_four_more_passes", 600);
        check_output("s5_reen_attempt", 32'(reen_attempt), 32'd5);

        // Replica 5 with result bit 0 stuck at 1 fails every attempt
        // (already at v0: 8 reads as 9) and is retired after three.
        $display("[TB] scenario: stuck replica 5");
        apply_reset();
        stuck5 = 1'b1;
        apply_stimulus(9'b000100000, 1'b1);
        repeat (3) sel_q.push_back(5);
        found = 1'b0;
        for (int n = 0; n < 300 && !found; n++) begin
            @(negedge clk);
            if (retired[5]) found = 1'b1;
        end
        check_output("s2_retired", 32'(retired), 32'h020);
        check_output("s2_attempts", 32'(attempt_count), 32'd3);
        expect_idle("s2_no_more_tests", 40);
        apply_stimulus(9'b000101000, 1'b1);
        sel_q.push_back(3);
        wait_queues("s2_skips_retired", 100);

        // Reset asserted during APPLY of v1 on replica 3.
        $display("[TB] scenario: reset during APPLY");
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (bist_sel[3]) found = 1'b1;
        end
        @(negedge clk);
        check_output("s6_in_apply", 32'({busy, bist_sel == '0}), 32'd3);
        reset = 1'b1;
        #1;
        check_output("s6_retired_cleared", 32'(retired), 32'd0);
        check_output("s6_busy", 32'(busy), 32'd0);
        check_output("s6_bist_sel", 32'(bist_sel), 32'd0);
        check_output("s6_bist_ab", bist_a | bist_b | 32'(bist_alucont), 32'd0);
        check_output("s6_reenable", 32'({reenable, reenable_idx}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
